// File: rtl/playback_sequencer_pkg.sv
// Shared encodings for the note recorder transport controller.
package playback_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_PLAY = 2'd1,
        ST_REC  = 2'd2
    } state_e;

    localparam int BM1     = 0;
    localparam int BM2     = 1;
    localparam int BM3     = 2;
    localparam int BM4     = 3;
    localparam int BTN_RUN = 4;
    localparam int NUM_BM  = 4;

endpackage

// File: rtl/playback_sequencer_button_sync.sv
// Two-flop synchronizer for a raw button, followed by a rising-edge one-cycle pulse.
module button_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/playback_sequencer.sv
// Transport controller: play/record/stop at a fixed note rate, bookmarks and memory write strobe.
module playback_sequencer
    import playback_sequencer_pkg::*;
#(
    parameter int LEN       = 65000,
    parameter int LEN_LOG_2 = 16,
    parameter int TICK_DIV  = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           b,
    input  logic                 sw1,
    input  logic                 loop_en,
    output logic [LEN_LOG_2-1:0] addr,
    output logic                 write_enable,
    output logic                 step,
    output logic [1:0]           state,
    output logic                 full
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [LEN_LOG_2-1:0] ADDR_LAST = LEN_LOG_2'(LEN - 1);

    logic [4:0]           btn_pulse;
    logic                 sw_meta_q, sw_sync_q;
    state_e               state_q, state_d;
    logic [LEN_LOG_2-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 full_q, full_d;
    logic [LEN_LOG_2-1:0] mark_q [NUM_BM];
    logic [LEN_LOG_2-1:0] mark_d [NUM_BM];
    logic                 bm_hit;
    logic [1:0]           bm_sel;
    logic                 running;
    logic                 tick;

    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
        button_sync u_sync (
            .clk   (clk),
            .rst_n (reset),
            .d_in  (b[gi]),
            .pulse (btn_pulse[gi])
        );
    end

    // Record switch only needs a clean level, no edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= 1'b0;
            sw_sync_q <= 1'b0;
        end else begin
            sw_meta_q <= sw1;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Descending scan so the lowest-numbered bookmark wins.
    always_comb begin
        bm_hit = 1'b0;
        bm_sel = 2'd0;
        for (int i = NUM_BM - 1; i >= 0; i--) begin
            if (btn_pulse[i]) begin
                bm_hit = 1'b1;
                bm_sel = i[1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        full_d       = full_q;
        mark_d       = mark_q;
        step         = 1'b0;
        write_enable = 1'b0;
        running      = (state_q != ST_STOP);
        tick         = running && (cnt_q == CNT_LAST);

        if (!running) begin
            if (bm_hit) mark_d[bm_sel] = addr_q;
            if (btn_pulse[BTN_RUN]) begin
                state_d = sw_sync_q ? ST_REC : ST_PLAY;
                full_d  = 1'b0;
            end
        end else begin
            state_d = sw_sync_q ? ST_REC : ST_PLAY;
            cnt_d   = tick ? '0 : cnt_q + 1'b1;
            if (bm_hit) begin
                addr_d = mark_q[bm_sel];
                cnt_d  = '0;
            end else if (tick) begin
                step         = 1'b1;
                write_enable = (state_q == ST_REC);
                if (state_q == ST_PLAY && loop_en && addr_q == mark_q[BM4]) begin
                    addr_d = mark_q[BM1];
                end else if (addr_q == ADDR_LAST) begin
                    addr_d = '0;
                    if (state_q == ST_REC) begin
                        state_d = ST_STOP;
                        full_d  = 1'b1;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            if (btn_pulse[BTN_RUN]) state_d = ST_STOP;
        end

        if (state_d == ST_STOP) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STOP;
            addr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            for (int i = 0; i < NUM_BM; i++) mark_q[i] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            mark_q  <= mark_d;
        end
    end

    assign addr  = addr_q;
    assign state = state_q;
    assign full  = full_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Randomized bench for playback_sequencer against a cycle-level behavioural transport model.
module tb_playback_sequencer;

    localparam int LEN = 16;
    localparam int LW  = 4;
    localparam int TD  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    b = 5'd0;
    logic          sw1 = 1'b0;
    logic          loop_en = 1'b0;
    logic [LW-1:0] addr;
    logic          write_enable;
    logic          step;
    logic [1:0]    state;
    logic          full;

    always #5 clk = ~clk;

    playback_sequencer #(.LEN(LEN), .LEN_LOG_2(LW), .TICK_DIV(TD)) dut (
        .clk          (clk),
        .reset        (reset),
        .b            (b),
        .sw1          (sw1),
        .loop_en      (loop_en),
        .addr         (addr),
        .write_enable (write_enable),
        .step         (step),
        .state        (state),
        .full         (full)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_on  = 1'b0;

    // Model: mode 0=stop 1=play 2=rec; raw-input history gives what the synchronizers present.
    int         m_mode, m_addr, m_cnt, m_full;
    int         m_mark [4];
    logic [4:0] hb0, hb1, hb2;
    logic       hs0, hs1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_addr = 0; m_cnt = 0; m_full = 0;
        for (int i = 0; i < 4; i++) m_mark[i] = 0;
        hb0 = '0; hb1 = '0; hb2 = '0; hs0 = 1'b0; hs1 = 1'b0;
    endtask

    task automatic model_outputs(output int e_step, output int e_we);
        logic [4:0] p;
        bit tick;
        p      = hb1 & ~hb2;
        tick   = (m_mode != 0) && (m_cnt == TD - 1);
        e_step = (tick && first_set(p[3:0]) < 0) ? 1 : 0;
        e_we   = (e_step == 1 && m_mode == 2) ? 1 : 0;
    endtask

    task automatic model_edge();
        logic [4:0] p;
        int bm, nm;
        bit tick, wrap_stop;
        if (!reset) begin
            model_reset();
            return;
        end
        p         = hb1 & ~hb2;
        bm        = first_set(p[3:0]);
        tick      = (m_mode != 0) && (m_cnt == TD - 1);
        wrap_stop = 1'b0;
        if (m_mode == 0) begin
            if (bm >= 0) m_mark[bm] = m_addr;
            if (p[4]) begin
                m_mode = hs1 ? 2 : 1;
                m_full = 0;
            end
        end else begin
            if (bm >= 0) begin
                m_addr = m_mark[bm];
                m_cnt  = 0;
            end else if (tick) begin
                m_cnt = 0;
                if (m_mode == 1 && loop_en && m_addr == m_mark[3]) m_addr = m_mark[0];
                else if (m_addr == LEN - 1) begin
                    m_addr = 0;
                    if (m_mode == 2) wrap_stop = 1'b1;
                end else m_addr = m_addr + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            nm = hs1 ? 2 : 1;
            if (wrap_stop) begin
                nm     = 0;
                m_full = 1;
            end
            if (p[4]) nm = 0;
            if (nm == 0) m_cnt = 0;
            m_mode = nm;
        end
        hb2 = hb1; hb1 = hb0; hb0 = b;
        hs1 = hs0; hs0 = sw1;
    endtask

    task automatic one_cycle();
        int e_step, e_we;
        @(negedge clk);
        model_outputs(e_step, e_we);
        chk("addr", addr, m_addr);
        chk("state", state, m_mode);
        chk("full", full, m_full);
        chk("step", step, e_step);
        chk("write_enable", write_enable, e_we);
        if (rand_on) begin
            if ($urandom_range(79) == 0) b[4] = ~b[4];
            for (int i = 0; i < 4; i++) if ($urandom_range(39) == 0) b[i] = ~b[i];
            if ($urandom_range(299) == 0) b[3:0] = 4'($urandom_range(15));
            if ($urandom_range(99) == 0) sw1 = ~sw1;
            if ($urandom_range(59) == 0) loop_en = ~loop_en;
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) one_cycle();
    endtask

    task automatic press(input int idx);
        b[idx] = 1'b1;
        run(3);
        b[idx] = 1'b0;
        run(2);
    endtask

    initial begin
        model_reset();
        run(3);
        #2 reset = 1'b1;
        run(2);

        sw1 = 1'b0;
        press(4);
        run(14);
        press(4);
        run(3);

        sw1 = 1'b1;
        press(4);
        run(14);
        press(4);
        run(3);
        sw1 = 1'b0;

        press(1);
        press(4);
        run(20);
        press(1);
        run(10);

        b[0] = 1'b1;
        b[2] = 1'b1;
        run(3);
        b = 5'd0;
        run(6);
        press(4);

        rand_on = 1'b1;
        run(5000);
        rand_on = 1'b0;
        b = 5'd0;
        run(5);

        sw1 = 1'b1;
        run(3);
        if (m_mode == 0) press(4);
        run(9);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_addr", addr, 0);
        chk("async_rst_we", write_enable, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_full", full, 0);
        chk("async_rst_step", step, 0);
        model_reset();
        run(2);
        reset = 1'b1;
        run(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
